// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter:
// response-owner FSM states, owner encoding and write-mask width.
package mem_arbiter_pkg;

  localparam int WMASK_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_RESP = 2'd1,
    D_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and memory port.
// slave = arbiter view, master = requester/memory (bench) view.
interface mem_arbiter_if #(
  parameter int ADDR_WITDH = 32,
  parameter int DATA_WITDH = 32
) ();
  import mem_arbiter_pkg::*;

  logic                  if_req;
  logic [ADDR_WITDH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WITDH-1:0] if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [WMASK_W-1:0]    d_wmask;
  logic [ADDR_WITDH-1:0] d_addr;
  logic [DATA_WITDH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WITDH-1:0] d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [WMASK_W-1:0]    mem_wmask;
  logic [ADDR_WITDH-1:0] mem_addr;
  logic [DATA_WITDH-1:0] mem_wdata;
  logic [DATA_WITDH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_wmask, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_wmask, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_wmask, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_wmask, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one single-port synchronous memory.
// Define MEM_ARB_STARVE_GUARD_EN to bound fetch starvation (STARVE_MAX).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WITDH = 32,
  parameter int DATA_WITDH = 32,
  parameter int STARVE_MAX = 4
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  owner_e     own;
  logic       if_gnt;
  logic       d_gnt;
  logic       force_if;

  logic [ADDR_WITDH-1:0] addr_sel;
  logic [DATA_WITDH-1:0] rdata;

  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("STARVE_MAX must be at least 1");
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign force_if = (cnt_q == CW'(STARVE_MAX));

  // Counts data wins only while fetch is actually waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (if_gnt || !bus.if_req)
      cnt_d = '0;
    else if (d_gnt)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign force_if = 1'b0;
`endif

  // Grants are gated by reset so nothing reaches memory while held.
  always_comb begin
    d_gnt  = rst & bus.d_req & ~(force_if & bus.if_req);
    if_gnt = rst & bus.if_req & ~d_gnt;
    own    = d_gnt ? OWN_D : OWN_IF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      d_gnt:   state_d = D_RESP;
      if_gnt:  state_d = IF_RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_sel = bus.if_addr;
    unique case (own)
      OWN_D:   addr_sel = bus.d_addr;
      default: addr_sel = bus.if_addr;
    endcase
    rdata = bus.mem_rdata;
  end

  always_comb begin
    bus.if_gnt    = if_gnt;
    bus.d_gnt     = d_gnt;
    bus.mem_en    = if_gnt | d_gnt;
    bus.mem_we    = d_gnt & bus.d_we;
    bus.mem_wmask = d_gnt ? bus.d_wmask : '0;
    bus.mem_addr  = addr_sel;
    bus.mem_wdata = bus.d_wdata;
    bus.if_rvalid = (state_q == IF_RESP);
    bus.d_rvalid  = (state_q == D_RESP);
    bus.if_rdata  = rdata;
    bus.d_rdata   = rdata;
  end

endmodule
